// File: rtl/pcs_pkg.sv
// Shared 1000BASE-X PCS definitions: sync FSM state encoding, comma and
// K28.5 constants, and the legal 5b/6b and 3b/4b sub-block lists.
package pcs_pkg;

  localparam int unsigned CG_W    = 10;
  localparam int unsigned STATE_W = 4;

  // Synchronization FSM states (13 states, 4-bit encoding)
  typedef enum logic [STATE_W-1:0] {
    ST_LOSS_OF_SYNC     = 4'd0,
    ST_COMMA_DETECT_1   = 4'd1,
    ST_ACQUIRE_SYNC_1   = 4'd2,
    ST_COMMA_DETECT_2   = 4'd3,
    ST_ACQUIRE_SYNC_2   = 4'd4,
    ST_COMMA_DETECT_3   = 4'd5,
    ST_SYNC_ACQUIRED_1  = 4'd6,
    ST_SYNC_ACQUIRED_2  = 4'd7,
    ST_SYNC_ACQUIRED_2A = 4'd8,
    ST_SYNC_ACQUIRED_3  = 4'd9,
    ST_SYNC_ACQUIRED_3A = 4'd10,
    ST_SYNC_ACQUIRED_4  = 4'd11,
    ST_SYNC_ACQUIRED_4A = 4'd12
  } sync_state_e;

  localparam logic [CG_W-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [CG_W-1:0] K28_5_RDP = 10'b1100000101;

  localparam logic [6:0] COMMA_POS = 7'b0011111;
  localparam logic [6:0] COMMA_NEG = 7'b1100000;

  // Legal 6b sub-blocks (abcdei), both disparities, D.0..D.31 and K.28
  function automatic logic legal_6b(input logic [5:0] s);
    case (s)
      6'b100111, 6'b011000, 6'b011101, 6'b100010, 6'b101101, 6'b010010,
      6'b110001, 6'b110101, 6'b001010, 6'b101001, 6'b011001, 6'b111000,
      6'b000111, 6'b111001, 6'b000110, 6'b100101, 6'b010101, 6'b110100,
      6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b101000, 6'b011011,
      6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010,
      6'b011010, 6'b111010, 6'b000101, 6'b110011, 6'b001100, 6'b100110,
      6'b010110, 6'b110110, 6'b001001, 6'b001110, 6'b101110, 6'b010001,
      6'b011110, 6'b100001, 6'b101011, 6'b010100, 6'b001111, 6'b110000:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  // Legal 4b sub-blocks (fghj), data and control, both disparities
  function automatic logic legal_4b(input logic [3:0] f);
    case (f)
      4'b1011, 4'b0100, 4'b1001, 4'b0101, 4'b1100, 4'b0011, 4'b1101,
      4'b0010, 4'b1010, 4'b0110, 4'b1110, 4'b0001, 4'b0111, 4'b1000:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

  // Control code groups: K28.x plus K23.7, K27.7, K29.7, K30.7
  function automatic logic k_code(input logic [5:0] s, input logic [3:0] f);
    logic k28;
    logic k7_rdn;
    logic k7_rdp;
    k28    = (s == 6'b001111) || (s == 6'b110000);
    k7_rdn = (f == 4'b1000) && ((s == 6'b111010) || (s == 6'b110110) ||
                                (s == 6'b101110) || (s == 6'b011110));
    k7_rdp = (f == 4'b0111) && ((s == 6'b000101) || (s == 6'b001001) ||
                                (s == 6'b010001) || (s == 6'b100001));
    return k28 || k7_rdn || k7_rdp;
  endfunction

endpackage

// File: rtl/pcs_sync_if.sv
// Code-group bus between the upstream stream source and the sync stage.
interface pcs_sync_if;
  import pcs_pkg::*;

  logic [CG_W-1:0] rx_code_group;
  logic            code_sync_status;
  logic            rx_even;
  logic [CG_W-1:0] sync_code_group;
  logic            sync_is_comma;
  logic            sync_cg_bad;

  modport master (
    output rx_code_group,
    input  code_sync_status, rx_even, sync_code_group, sync_is_comma, sync_cg_bad
  );

  modport slave (
    input  rx_code_group,
    output code_sync_status, rx_even, sync_code_group, sync_is_comma, sync_cg_bad
  );

endinterface

// File: rtl/pcs_cg_check.sv
// Combinational code-group classifier: comma, invalid and control flags.
module pcs_cg_check
  import pcs_pkg::*;
(
  input  logic [CG_W-1:0] code_group,
  output logic            is_comma,
  output logic            cg_bad,
  output logic            is_k
);

  // Comma is a 7-bit prefix match; invalid means either sub-block illegal
  always_comb begin
    is_comma = (code_group[9:3] == COMMA_POS) || (code_group[9:3] == COMMA_NEG);
    cg_bad   = !legal_6b(code_group[9:4]) || !legal_4b(code_group[3:0]);
    is_k     = k_code(code_group[9:4], code_group[3:0]);
  end

endmodule

// File: rtl/pcs_sync.sv
// 1000BASE-X PCS code-group synchronization: comma acquisition, even/odd
// tracking and code_sync_status, with registered forwarding of the stream.
// Optional build macro PCS_SYNC_SIGNAL_DETECT_EN adds a signal_detect input.
module pcs_sync
  import pcs_pkg::*;
#(
  parameter int unsigned COMMA_TARGET = 3,
  parameter int unsigned GOOD_CGS_MAX = 3
) (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset,
`ifdef PCS_SYNC_SIGNAL_DETECT_EN
  input  logic       signal_detect,
`endif
  pcs_sync_if.slave  sync_bus
);

  localparam int unsigned GC_W =
    ($clog2(GOOD_CGS_MAX + 1) > 2) ? $clog2(GOOD_CGS_MAX + 1) : 2;

  // Where a confirmed comma+/D/ leads, depending on how many commas are required
  localparam sync_state_e AFTER_CD1 =
    (COMMA_TARGET <= 1) ? ST_SYNC_ACQUIRED_1 : ST_ACQUIRE_SYNC_1;
  localparam sync_state_e AFTER_CD2 =
    (COMMA_TARGET <= 2) ? ST_SYNC_ACQUIRED_1 : ST_ACQUIRE_SYNC_2;

  sync_state_e     state_q, state_d;
  logic [GC_W-1:0] good_cgs_q, good_cgs_d;
  logic            rx_even_q, rx_even_d;
  logic            status_q, status_d;
  logic [CG_W-1:0] cg_q;
  logic            comma_q;
  logic            bad_q;

  logic            is_comma;
  logic            cg_bad;
  logic            is_k;
  logic            is_data;
  logic            cg_good;
  logic [GC_W-1:0] gc_inc;
  logic            gc_hit;
  logic            sd_ok;

  pcs_cg_check u_cg_check (
    .code_group (sync_bus.rx_code_group),
    .is_comma   (is_comma),
    .cg_bad     (cg_bad),
    .is_k       (is_k)
  );

`ifdef PCS_SYNC_SIGNAL_DETECT_EN
  logic [1:0] sd_sync_q;

  // Two-flop synchronizer for the asynchronous signal_detect
  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      sd_sync_q <= 2'b00;
    end else begin
      sd_sync_q <= {sd_sync_q[0], signal_detect};
    end
  end

  assign sd_ok = sd_sync_q[1];
`else
  assign sd_ok = 1'b1;
`endif

  // Per-group qualifiers; cg_good uses the parity before this edge's update
  always_comb begin
    is_data = !cg_bad && !is_k;
    cg_good = !cg_bad && !(is_comma && rx_even_q);
    gc_inc  = (&good_cgs_q) ? good_cgs_q : good_cgs_q + GC_W'(1);
    gc_hit  = gc_inc >= GC_W'(GOOD_CGS_MAX);
  end

  // Next-state, good-group counter, parity and status
  always_comb begin
    state_d    = state_q;
    good_cgs_d = good_cgs_q;
    rx_even_d  = !rx_even_q;
    status_d   = 1'b0;

    case (state_q)
      ST_LOSS_OF_SYNC: begin
        if (is_comma) state_d = ST_COMMA_DETECT_1;
      end
      ST_COMMA_DETECT_1: state_d = is_data ? AFTER_CD1 : ST_LOSS_OF_SYNC;
      ST_COMMA_DETECT_2: state_d = is_data ? AFTER_CD2 : ST_LOSS_OF_SYNC;
      ST_COMMA_DETECT_3: state_d = is_data ? ST_SYNC_ACQUIRED_1 : ST_LOSS_OF_SYNC;
      ST_ACQUIRE_SYNC_1: begin
        if (cg_bad || (is_comma && rx_even_q)) state_d = ST_LOSS_OF_SYNC;
        else if (is_comma)                     state_d = ST_COMMA_DETECT_2;
      end
      ST_ACQUIRE_SYNC_2: begin
        if (cg_bad || (is_comma && rx_even_q)) state_d = ST_LOSS_OF_SYNC;
        else if (is_comma)                     state_d = ST_COMMA_DETECT_3;
      end
      ST_SYNC_ACQUIRED_1: begin
        if (!cg_good) state_d = ST_SYNC_ACQUIRED_2;
      end
      // The good group that leaves SA_n is the first of the recovery run
      ST_SYNC_ACQUIRED_2: begin
        good_cgs_d = cg_good ? GC_W'(1) : '0;
        state_d    = cg_good ? ST_SYNC_ACQUIRED_2A : ST_SYNC_ACQUIRED_3;
      end
      ST_SYNC_ACQUIRED_2A: begin
        good_cgs_d = gc_inc;
        if (!cg_good)    state_d = ST_SYNC_ACQUIRED_3;
        else if (gc_hit) state_d = ST_SYNC_ACQUIRED_1;
      end
      ST_SYNC_ACQUIRED_3: begin
        good_cgs_d = cg_good ? GC_W'(1) : '0;
        state_d    = cg_good ? ST_SYNC_ACQUIRED_3A : ST_SYNC_ACQUIRED_4;
      end
      ST_SYNC_ACQUIRED_3A: begin
        good_cgs_d = gc_inc;
        if (!cg_good)    state_d = ST_SYNC_ACQUIRED_4;
        else if (gc_hit) state_d = ST_SYNC_ACQUIRED_2;
      end
      ST_SYNC_ACQUIRED_4: begin
        good_cgs_d = cg_good ? GC_W'(1) : '0;
        state_d    = cg_good ? ST_SYNC_ACQUIRED_4A : ST_LOSS_OF_SYNC;
      end
      ST_SYNC_ACQUIRED_4A: begin
        good_cgs_d = gc_inc;
        if (!cg_good)    state_d = ST_LOSS_OF_SYNC;
        else if (gc_hit) state_d = ST_SYNC_ACQUIRED_3;
      end
      default: state_d = ST_LOSS_OF_SYNC;
    endcase

    if (!sd_ok) state_d = ST_LOSS_OF_SYNC;

    if (state_d inside {ST_COMMA_DETECT_1, ST_COMMA_DETECT_2, ST_COMMA_DETECT_3})
      rx_even_d = 1'b1;

    status_d = state_d inside {ST_SYNC_ACQUIRED_1,  ST_SYNC_ACQUIRED_2,
                               ST_SYNC_ACQUIRED_2A, ST_SYNC_ACQUIRED_3,
                               ST_SYNC_ACQUIRED_3A, ST_SYNC_ACQUIRED_4,
                               ST_SYNC_ACQUIRED_4A};
  end

  // State and output registers; forwarded group and flags share one stage
  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_q    <= ST_LOSS_OF_SYNC;
      good_cgs_q <= '0;
      rx_even_q  <= 1'b0;
      status_q   <= 1'b0;
      cg_q       <= '0;
      comma_q    <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cgs_q <= good_cgs_d;
      rx_even_q  <= rx_even_d;
      status_q   <= status_d;
      cg_q       <= sync_bus.rx_code_group;
      comma_q    <= is_comma;
      bad_q      <= cg_bad;
    end
  end

  assign sync_bus.code_sync_status = status_q;
  assign sync_bus.rx_even          = rx_even_q;
  assign sync_bus.sync_code_group  = cg_q;
  assign sync_bus.sync_is_comma    = comma_q;
  assign sync_bus.sync_cg_bad      = bad_q;

endmodule

// File: tb/tb_pcs_sync.sv
// Testbench for pcs_sync: directed scenarios plus a randomized stream,
// checked against a behavioural model of the synchronization rules.
module tb_pcs_sync;

  localparam int TARGET   = 3;
  localparam int GOOD_MAX = 3;

  localparam logic [9:0] K28_5 = 10'b0011111010;
  localparam logic [9:0] D16_2 = 10'b1001000101;
  localparam logic [9:0] BADCG = 10'b1111111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef PCS_SYNC_SIGNAL_DETECT_EN
  logic signal_detect = 1'b1;
`endif

  pcs_sync_if bus ();

  pcs_sync #(
    .COMMA_TARGET (TARGET),
    .GOOD_CGS_MAX (GOOD_MAX)
  ) dut (
    .GTX_CLK       (clk),
    .mr_main_reset (rst_n),
`ifdef PCS_SYNC_SIGNAL_DETECT_EN
    .signal_detect (signal_detect),
`endif
    .sync_bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [5:0] legal6 [48] = '{
    6'b100111, 6'b011000, 6'b011101, 6'b100010, 6'b101101, 6'b010010,
    6'b110001, 6'b110101, 6'b001010, 6'b101001, 6'b011001, 6'b111000,
    6'b000111, 6'b111001, 6'b000110, 6'b100101, 6'b010101, 6'b110100,
    6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b101000, 6'b011011,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010,
    6'b011010, 6'b111010, 6'b000101, 6'b110011, 6'b001100, 6'b100110,
    6'b010110, 6'b110110, 6'b001001, 6'b001110, 6'b101110, 6'b010001,
    6'b011110, 6'b100001, 6'b101011, 6'b010100, 6'b001111, 6'b110000};

  logic [3:0] data4 [12] = '{
    4'b1011, 4'b0100, 4'b1001, 4'b0101, 4'b1100, 4'b0011,
    4'b1101, 4'b0010, 4'b1010, 4'b0110, 4'b1110, 4'b0001};

  // Behavioural model: acquisition progress, error level, recovery run
  bit         m_sync;
  bit         m_even;
  int         m_commas;
  bit         m_wait_d;
  int         m_bad;
  int         m_run;
  bit         m_sd1;
  bit         m_sd2;
  bit         exp_status;
  bit         exp_even;
  logic [9:0] exp_cg;
  bit         exp_comma;
  bit         exp_bad;

  function automatic void classify(input logic [9:0] cg, output bit comma,
                                   output bit bad, output bit k);
    logic [5:0] six;
    logic [3:0] four;
    bit         ok6;
    six   = cg[9:4];
    four  = cg[3:0];
    comma = (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
    ok6   = 1'b0;
    foreach (legal6[i]) if (legal6[i] == six) ok6 = 1'b1;
    bad   = !ok6 || (four == 4'b0000) || (four == 4'b1111);
    k     = (six inside {6'b001111, 6'b110000}) ||
            ((four == 4'b1000) && (six inside {6'b111010, 6'b110110, 6'b101110, 6'b011110})) ||
            ((four == 4'b0111) && (six inside {6'b000101, 6'b001001, 6'b010001, 6'b100001}));
  endfunction

  function automatic logic [9:0] rand_data();
    logic [5:0] six;
    six = 6'b001111;
    while (six == 6'b001111 || six == 6'b110000)
      six = legal6[$urandom_range(47)];
    return {six, data4[$urandom_range(11)]};
  endfunction

  task automatic model_reset();
    m_sync = 0; m_even = 0; m_commas = 0; m_wait_d = 0; m_bad = 0; m_run = 0;
    m_sd1 = 0; m_sd2 = 0;
    exp_status = 0; exp_even = 0; exp_cg = 10'h000; exp_comma = 0; exp_bad = 0;
  endtask

  task automatic lose();
    m_sync = 0; m_commas = 0; m_wait_d = 0; m_bad = 0; m_run = 0;
  endtask

  task automatic model_step(input logic [9:0] cg, input bit sd_now);
    bit c, b, k, good, enter_cd, sd_eff;
    classify(cg, c, b, k);
`ifdef PCS_SYNC_SIGNAL_DETECT_EN
    sd_eff = m_sd2;
    m_sd2  = m_sd1;
    m_sd1  = sd_now;
`else
    sd_eff = sd_now;
`endif
    good     = !b && !(c && m_even);
    enter_cd = 0;
    if (!sd_eff) begin
      lose();
    end else if (m_sync) begin
      if (good) begin
        if (m_bad > 0) begin
          m_run++;
          if (m_run == GOOD_MAX) begin m_bad--; m_run = 0; end
        end
      end else begin
        m_bad++;
        m_run = 0;
        if (m_bad == 4) lose();
      end
    end else if (m_wait_d) begin
      m_wait_d = 0;
      if (!b && !k) begin
        if (m_commas == TARGET) begin m_sync = 1; m_bad = 0; m_run = 0; end
      end else begin
        m_commas = 0;
      end
    end else if (m_commas == 0) begin
      if (c) begin m_commas = 1; m_wait_d = 1; enter_cd = 1; end
    end else begin
      if (b || (c && m_even)) m_commas = 0;
      else if (c) begin m_commas++; m_wait_d = 1; enter_cd = 1; end
    end
    m_even     = enter_cd ? 1'b1 : !m_even;
    exp_status = m_sync;
    exp_even   = m_even;
    exp_cg     = cg;
    exp_comma  = c;
    exp_bad    = b;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all();
    chk("status", 10'(bus.code_sync_status), 10'(exp_status));
    chk("rx_even", 10'(bus.rx_even), 10'(exp_even));
    chk("sync_cg", bus.sync_code_group, exp_cg);
    chk("is_comma", 10'(bus.sync_is_comma), 10'(exp_comma));
    chk("cg_bad", 10'(bus.sync_cg_bad), 10'(exp_bad));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_status"}, 10'(bus.code_sync_status), 10'd0);
    chk({tag, "_even"}, 10'(bus.rx_even), 10'd0);
    chk({tag, "_cg"}, bus.sync_code_group, 10'h000);
    chk({tag, "_comma"}, 10'(bus.sync_is_comma), 10'd0);
    chk({tag, "_bad"}, 10'(bus.sync_cg_bad), 10'd0);
  endtask

  // Entered and left at a falling edge: check last step, drive next group
  task automatic cycle(input logic [9:0] cg);
    bit sd;
    cmp_all();
    bus.rx_code_group = cg;
`ifdef PCS_SYNC_SIGNAL_DETECT_EN
    sd = signal_detect;
`else
    sd = 1'b1;
`endif
    model_step(cg, sd);
    @(negedge clk);
  endtask

  task automatic send_i2(input int pairs);
    for (int p = 0; p < pairs; p++) begin
      cycle(K28_5);
      cycle(D16_2);
    end
  endtask

  // Asynchronous reset in the middle of a cycle
  task automatic mid_reset();
    cmp_all();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    model_reset();
    bus.rx_code_group = 10'h000;
    repeat (2) @(negedge clk);
    chk_reset_vals("held_rst");
    rst_n = 1'b1;
  endtask

  initial begin
    int  r;
    bit  i2_phase;

    bus.rx_code_group = 10'h000;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // Idle in LOSS_OF_SYNC: parity toggles, no sync
    for (int k = 1; k <= 6; k++) begin
      cycle(10'h000);
      chk("idle_even", 10'(bus.rx_even), 10'(k % 2));
    end
    chk("idle_status", 10'(bus.code_sync_status), 10'd0);

    // Acquire on /I2/: sync after the third D16.2
    send_i2(2);
    chk("acq_pre", 10'(bus.code_sync_status), 10'd0);
    send_i2(1);
    chk("acq_post", 10'(bus.code_sync_status), 10'd1);
    send_i2(4);
    cycle(K28_5);
    chk("k_even", 10'(bus.rx_even), 10'd1);

    // Misaligned comma, then three good groups to recover
    cycle(K28_5);
    chk("misalign_status", 10'(bus.code_sync_status), 10'd1);
    cycle(K28_5);
    cycle(D16_2);
    cycle(K28_5);
    chk("recover_status", 10'(bus.code_sync_status), 10'd1);

    // Four invalid groups with short good runs between them
    cycle(BADCG);
    cycle(D16_2);
    cycle(BADCG);
    cycle(D16_2);
    cycle(D16_2);
    cycle(BADCG);
    chk("loss_pre", 10'(bus.code_sync_status), 10'd1);
    cycle(D16_2);
    cycle(BADCG);
    chk("loss_post", 10'(bus.code_sync_status), 10'd0);

    // Reset between the second and third comma restarts acquisition
    cycle(10'h000);
    send_i2(2);
    mid_reset();
    cycle(10'h000);
    cycle(10'h000);
    send_i2(2);
    chk("reacq_pre", 10'(bus.code_sync_status), 10'd0);
    send_i2(1);
    chk("reacq_post", 10'(bus.code_sync_status), 10'd1);

`ifdef PCS_SYNC_SIGNAL_DETECT_EN
    // Drop signal_detect while synced: status falls on the third edge
    signal_detect = 1'b0;
    cycle(K28_5);
    cycle(D16_2);
    chk("sd_pre", 10'(bus.code_sync_status), 10'd1);
    cycle(K28_5);
    chk("sd_post", 10'(bus.code_sync_status), 10'd0);
    cycle(D16_2);
    send_i2(3);
    chk("sd_hold", 10'(bus.code_sync_status), 10'd0);
    signal_detect = 1'b1;
    cycle(10'h000);
    cycle(10'h000);
    send_i2(3);
    chk("sd_reacq", 10'(bus.code_sync_status), 10'd1);
`endif

    // Randomized mix of /I2/, data, arbitrary groups and stray commas
    i2_phase = 1'b0;
    for (int n = 0; n < 2500; n++) begin
      r = int'($urandom_range(99));
      if (r < 70) begin
        cycle(i2_phase ? D16_2 : K28_5);
        i2_phase = !i2_phase;
      end else if (r < 85) begin
        cycle(rand_data());
      end else if (r < 95) begin
        cycle(10'($urandom));
      end else begin
        cycle(K28_5);
      end
    end
    cmp_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcs_sync.md
Name: pcs_sync

Overview:
- 1000BASE-X PCS code-group synchronization stage (IEEE 802.3 Clause 36, Fig. 36-9).
- Sits directly downstream of the PCS transmit block: consumes its 10-bit code-group stream (loopback/channel) and feeds the PCS receive block.
- Acquires comma alignment, tracks even/odd code-group position, asserts code_sync_status, and forwards registered code groups with flags.

Parameters:
- COMMA_TARGET, 3: commas with intervening good /D/ required to reach sync (legal range 1..3).
- GOOD_CGS_MAX, 3: consecutive good code groups needed to step back one SYNC_ACQUIRED level.

Ports:
- GTX_CLK  input  1  rising-edge clock, one code group per cycle.
- mr_main_reset  input  1  asynchronous active-low reset.
- rx_code_group  input  10  incoming code group; bit 9 = 'a' (first transmitted), bit 0 = 'j'.
- code_sync_status  output  1  1 = OK, 0 = FAIL.
- rx_even  output  1  1 = current forwarded code group is in an even position.
- sync_code_group  output  10  registered copy of rx_code_group.
- sync_is_comma  output  1  forwarded code group contains a comma.
- sync_cg_bad  output  1  forwarded code group is invalid.

Behaviour:
- Reset (async, mr_main_reset=0): state LOSS_OF_SYNC, good_cgs=0, code_sync_status=0, rx_even=0, sync_code_group=10'h000, sync_is_comma=0, sync_cg_bad=0.
- Latency: all outputs registered; a code group presented at edge N appears on sync_* after edge N. code_sync_status and rx_even correspond to the same forwarded code group.
- Comma: rx_code_group[9:3] == 7'b0011111 or 7'b1100000.
- Invalid (cgbad): 6b sub-block [9:4] not a legal 5b/6b code, or 4b sub-block [3:0] not a legal 3b/4b code. Running-disparity errors are not flagged.
- cggood = !cgbad && !(comma && rx_even==1), using the pre-update rx_even.
- /D/ = valid and not a K code group.
- rx_even update on every edge:
  - Set to 1 when entering any COMMA_DETECT_x.
  - Otherwise toggles.
- States and transitions:
  - LOSS_OF_SYNC: comma -> COMMA_DETECT_1; otherwise stay.
  - COMMA_DETECT_k: /D/ -> ACQUIRE_SYNC_k, or SYNC_ACQUIRED_1 when k == COMMA_TARGET; anything else -> LOSS_OF_SYNC.
  - ACQUIRE_SYNC_k: cgbad, or comma with rx_even=1 -> LOSS_OF_SYNC; comma with rx_even=0 -> COMMA_DETECT_k+1; otherwise stay.
  - SYNC_ACQUIRED_1: cggood -> stay; else -> SYNC_ACQUIRED_2.
  - SYNC_ACQUIRED_n (n = 2..4): clears good_cgs; cggood -> SYNC_ACQUIRED_nA; else -> SYNC_ACQUIRED_n+1, or LOSS_OF_SYNC when n = 4.
  - SYNC_ACQUIRED_nA: increments good_cgs (saturating, 2-bit minimum width).
    - cggood with good_cgs reaching GOOD_CGS_MAX -> SYNC_ACQUIRED_n-1.
    - cggood otherwise -> stay.
    - not cggood -> SYNC_ACQUIRED_n+1, or LOSS_OF_SYNC when n = 4.
- code_sync_status = 1 in all SYNC_ACQUIRED_* states, 0 elsewhere; it changes on the same edge as the state change.
- Reset mid-frame: immediate return to LOSS_OF_SYNC; comma acquisition restarts from scratch.

Optional Feature:
- Macro: PCS_SYNC_SIGNAL_DETECT_EN.
- Defined: adds input signal_detect (1 bit), synchronised by two flops inside the block. A synchronised 0 forces LOSS_OF_SYNC and code_sync_status=0 on the next edge, overriding all other transitions. Acquisition resumes only after it returns to 1.
- Undefined: port absent; behaviour as if signal_detect is permanently 1.

Decomposition:
- Shared package pcs_pkg:
  - State encoding constants (13 states, 4-bit).
  - K28.5 RD-/RD+ constants 10'b0011111010 / 10'b1100000101.
  - Comma patterns.
  - Legal 6b and 4b sub-block lists.
- Sub-module pcs_cg_check: combinational; rx_code_group -> is_comma, cg_bad, is_k. Reused by the receive block.

Test Plan:
- Reset then idle: hold mr_main_reset=0 for 2 cycles, drive 10'h000 -> code_sync_status=0, rx_even toggles every cycle, state stays LOSS_OF_SYNC.
- Acquire: repeat /I2/ (0011111010, 1001000101) -> code_sync_status=1 one cycle after the third D16.2; rx_even=1 on every forwarded K28.5 thereafter.
- Misaligned comma: after sync, inject K28.5 at an odd position (rx_even=1 before it) -> SYNC_ACQUIRED_2. Then 3 good /I2/ code groups -> back to SYNC_ACQUIRED_1; code_sync_status stays 1 throughout.
- Loss: after sync, inject 4 invalid code groups (10'b1111111111), spaced by fewer than 3 good code groups -> code_sync_status=0 exactly one cycle after the 4th.
- Reset mid-acquisition: assert mr_main_reset=0 between the 2nd and 3rd comma -> outputs at reset values asynchronously; 3 further /I2/ pairs are needed to regain sync.
- With PCS_SYNC_SIGNAL_DETECT_EN: drop signal_detect while synced -> code_sync_status=0 three edges later.
